mmio_uart_tx: RTL and testbench

Memory-mapped serial transmitter that responds to the CPU's memory port: address, wr, write data, and read data with one-cycle synchronous read latency. CPU stores push bytes into a TX FIFO, and CPU loads return a status word. An FSM serialises FIFO bytes as 8N1 frames on tx. It sits beside the main memory on the same address/data bus, and its read data is OR-combined with memory read data.

---
 rtl/mmio_uart_tx_if.sv | 11 +
 rtl/mmio_uart_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU memory-port signals shared by main memory and the
// memory-mapped UART transmitter (address, store strobe, store/load data).
interface mmio_uart_tx_if;
  logic [31:0] address;
  logic        wr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output address, wr, data_in, input data_out);
  modport slave  (input address, wr, data_in, output data_out);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter.
//   BASE+0x0 DATA   : store pushes data_in[7:0] into the TX FIFO, load reads 0
//   BASE+0x4 STATUS : {16'b0, count[7:0], 4'b0, overflow, busy_fsm, empty, full}
//   BASE+0x8/0xC    : read 0, stores ignored
// Read data is registered (one-cycle latency) and zero when not selected so
// it can be OR-combined with main-memory read data.
// Optional: define MMIO_UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1 framing).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- decode
  logic       sel;
  logic [1:0] off;
  logic       push_req;
  logic       rd_status;

  assign sel       = (bus.address[31:4] == BASE_ADDR[31:4]);
  assign off       = bus.address[3:2];
  assign push_req  = bus.wr & sel & (off == 2'd0);
  assign rd_status = ~bus.wr & sel & (off == 2'd1);

  // ---------------------------------------------------------------- FIFO
  // Pointers carry one extra wrap bit so count = wptr - rptr covers 0..DEPTH.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, count;
  logic        full, empty, push, pop, ovf_set;
  logic [7:0]  head;

  assign count   = wptr - rptr;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign head    = mem[rptr[AW-1:0]];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = push_req & (~full | pop);
  assign ovf_set = push_req & ~push;

  // FIFO pointer update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // FIFO storage write; contents need no reset since pointers gate them
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= bus.data_in[7:0];
  end

  // ---------------------------------------------------------------- FSM
  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_q, tx_n;
  logic          load;
`ifdef MMIO_UART_TX_PARITY_EN
  logic          par_q, par_n;
`endif

  // FSM state, baud counter, shifter and registered line output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      tx_q    <= tx_n;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  // FSM next state; tx is computed for the next cycle so it changes on the
  // same edge as the state it belongs to
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    if (state != S_IDLE && baud != '0) baud_n = baud - BAUD_ONE;

    unique case (state)
      S_IDLE: begin
        if (!empty) load = 1'b1;
      end
      S_START: begin
        if (baud == '0) begin
          state_n = S_DATA;
          baud_n  = BAUD_MAX;
          bit_n   = 3'd0;
          tx_n    = shreg[0];
        end
      end
      S_DATA: begin
        if (baud == '0) begin
          baud_n = BAUD_MAX;
          if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_n = S_PARITY;
            tx_n    = par_q;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n   = bit_idx + 3'd1;
            shreg_n = {1'b0, shreg[7:1]};
            tx_n    = shreg[1];
          end
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud == '0) begin
          state_n = S_STOP;
          baud_n  = BAUD_MAX;
          tx_n    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud == '0) begin
          if (!empty) begin
            load = 1'b1;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // Start a new frame straight from IDLE or STOP (no idle gap)
    if (load) begin
      pop     = 1'b1;
      shreg_n = head;
      state_n = S_START;
      baud_n  = BAUD_MAX;
      tx_n    = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
      par_n   = ^head;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = (state != S_IDLE) | ~empty;

  // ---------------------------------------------------------------- read port
  logic [8:0]  cnt9;
  logic [31:0] rdata;
  logic        ovf;
  logic        unused_bits;

  assign cnt9        = 9'(count);
  assign unused_bits = ^{bus.address[1:0], bus.data_in[31:8], cnt9[8]};

  // Status word mux; everything other than a STATUS load reads zero
  always_comb begin
    rdata = '0;
    if (rd_status)
      rdata = {16'b0, cnt9[7:0], 4'b0, ovf, (state != S_IDLE), empty, full};
  end

  // Registered read data and sticky overflow (set beats clear-on-read)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.data_out <= '0;
      ovf          <= 1'b0;
    end else begin
      bus.data_out <= rdata;
      if (ovf_set)        ovf <= 1'b1;
      else if (rd_status) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx (CLKS_PER_BIT=4,
// FIFO_DEPTH=8). Bytes expected on the line are queued when written and
// popped by a line monitor that decodes each frame cycle by cycle.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int CPB = 4;
  localparam int DEPTH = 8;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic clk;
  logic reset;
  logic tx, busy;
  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .tx    (tx),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int frames_rx = 0;
  logic mon_on = 1'b1;
  logic b2b_chk = 1'b0;
  logic gap_vld = 1'b0;
  int last_end = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.address = a;
    bus_if.wr      = 1'b1;
    bus_if.data_in = d;
    @(negedge clk);
    bus_if.wr      = 1'b0;
    bus_if.address = 32'h0;
    bus_if.data_in = 32'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.address = a;
    bus_if.wr      = 1'b0;
    @(negedge clk);
    d = bus_if.data_out;
    bus_if.address = 32'h0;
  endtask

  task automatic wait_frames(input int n, input int bound);
    int k = 0;
    while (frames_rx < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("frames", frames_rx, n);
  endtask

  task automatic busy_len(input string tag, input int exp);
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, exp);
  endtask

  // Line monitor: decode each frame, checking every cycle of every bit
  initial begin
    logic [7:0] b;
    logic ok;
    int c0;
`ifdef MMIO_UART_TX_PARITY_EN
    logic p;
`endif
    forever begin
      @(negedge clk);
      if (mon_on && reset === 1'b1 && tx === 1'b0) begin
        c0 = cyc;
        if (b2b_chk && gap_vld) chk("gap", c0 - last_end, 1);
        ok = 1'b1;
        for (int k = 1; k < CPB; k++) begin
          @(negedge clk);
          if (tx !== 1'b0) ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          b[i] = tx;
          for (int k = 1; k < CPB; k++) begin
            @(negedge clk);
            if (tx !== b[i]) ok = 1'b0;
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        @(negedge clk);
        p = tx;
        for (int k = 1; k < CPB; k++) begin
          @(negedge clk);
          if (tx !== p) ok = 1'b0;
        end
        chk("parity", p, ^b);
`endif
        for (int k = 0; k < CPB; k++) begin
          @(negedge clk);
          if (tx !== 1'b1) ok = 1'b0;
        end
        last_end = cyc;
        gap_vld  = 1'b1;
        chk("bit_hold", ok, 1'b1);
        if (exp_q.size() == 0) chk("extra_frame", b, 32'hFFFF_FFFF);
        else chk("rx_byte", b, exp_q.pop_front());
        frames_rx++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0] rb;
    int lows;
    reset          = 1'b0;
    bus_if.address = 32'h0;
    bus_if.wr      = 1'b0;
    bus_if.data_in = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dout", bus_if.data_out, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    bus_rd(BASE + 32'h4, rd);
    chk("rst_status", rd, 32'h0000_0002);
    chk("idle_tx", tx, 1'b1);

    // single byte from idle
    exp_q.push_back(8'hA5);
    bus_wr(BASE, 32'hFFFF_FFA5);
    busy_len("single_busy_len", FRAME + 1);
    wait_frames(1, 100);
    bus_rd(BASE + 32'h4, rd);
    chk("single_status", rd, 32'h0000_0002);

    // overflow: 0x00 goes to the shifter, 0x01..0x08 fill, 0x09 dropped
    gap_vld = 1'b0;
    b2b_chk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < DEPTH + 1) exp_q.push_back(8'(i));
      bus_wr(BASE, 32'(i));
    end
    bus_rd(BASE + 32'h4, rd);
    chk("ovf_status1", rd, 32'h0000_080D);
    bus_rd(BASE + 32'h4, rd);
    chk("ovf_status2", rd, 32'h0000_0805);
    wait_frames(10, 10 * FRAME + 100);

    // short random burst, also back to back
    gap_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      bus_wr(BASE, {24'h0, rb});
    end
    wait_frames(13, 4 * FRAME + 100);
    b2b_chk = 1'b0;
    repeat (3) @(negedge clk);
    chk("burst_busy", busy, 1'b0);

    // decode: STATUS, next window and unused offsets ignore stores
    bus_wr(BASE + 32'h4, 32'h55);
    bus_wr(BASE + 32'h10, 32'h66);
    bus_wr(BASE + 32'h8, 32'h77);
    bus_rd(BASE + 32'h4, rd);
    chk("decode_status", rd, 32'h0000_0002);
    bus_rd(32'h0000_0000, rd);
    chk("rd_unsel", rd, 32'h0);
    bus_rd(BASE + 32'h8, rd);
    chk("rd_off8", rd, 32'h0);
    bus_rd(BASE, rd);
    chk("rd_data", rd, 32'h0);
    repeat (FRAME) @(negedge clk);
    chk("decode_frames", frames_rx, 13);

    // reset during the third data bit (bit2 of 0x3A is 0)
    mon_on = 1'b0;
    bus_wr(BASE, 32'h3A);
    repeat (14) @(negedge clk);
    chk("pre_rst_tx", tx, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_rd(BASE + 32'h4, rd);
    chk("postrst_status", rd, 32'h0000_0002);
    lows = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("postrst_quiet", lows, 0);
    mon_on = 1'b1;

`ifdef MMIO_UART_TX_PARITY_EN
    exp_q.push_back(8'h07);
    bus_wr(BASE, 32'h07);
    busy_len("parity_busy_len", 11 * CPB + 1);
    wait_frames(14, 100);
`endif

    repeat (5) @(negedge clk);
    chk("q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
